// File: rtl/sdio_cis_arbiter.sv
// Round-robin share of the single-port CIS ROM among NUM_REQ CMD52 readers, with window check and base translation.
// In-window read acks 3 cycles after grant (4 per read); out-of-window acks after 1; requesters hold i_req until ack.
module sdio_cis_arbiter #(
    parameter int          NUM_REQ  = 2,
    parameter logic [17:0] CIS_BASE = 18'h01000,
    parameter int          CIS_SIZE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*18-1:0] i_addr,
    output logic [NUM_REQ-1:0]    o_ack,
    output logic                  o_err,
    output logic [7:0]            o_data,
    output logic                  o_busy,
    output logic                  o_cis_activate,
    output logic                  o_cis_data_stb,
    output logic [17:0]           o_cis_address,
    input  logic [7:0]            i_cis_data
);
    localparam int          IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [18:0] WIN_LO = {1'b0, CIS_BASE};
    localparam logic [18:0] WIN_HI = WIN_LO + 19'(CIS_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [17:0]     addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            err_q, err_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [17:0]     pick_addr;
    logic            pick_in_win;

    // Walk downwards so the requester closest after last_q is the final (winning) assignment.
    always_comb begin
        int k;
        k        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = (int'(last_q) + i) % NUM_REQ;
            if (i_req[IW'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
        end
    end

    assign pick_addr   = i_addr[int'(pick_idx)*18 +: 18];
    assign pick_in_win = ({1'b0, pick_addr} >= WIN_LO) && ({1'b0, pick_addr} < WIN_HI);

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        addr_d         = addr_q;
        data_d         = data_q;
        err_d          = err_q;
        o_busy         = (state_q != S_IDLE);
        o_cis_activate = 1'b0;
        o_cis_data_stb = 1'b0;
        o_cis_address  = '0;
        o_ack          = '0;
        o_data         = '0;
        o_err          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d  = pick_idx;
                    last_d = pick_idx;
                    addr_d = pick_addr;
                    if (pick_in_win) begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = 8'h00;
                        state_d = S_RESPOND;
                    end
                end
            end
            S_ISSUE: begin
                o_cis_activate = 1'b1;
                o_cis_data_stb = 1'b1;
                o_cis_address  = addr_q - CIS_BASE;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                data_d  = i_cis_data;
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                o_ack   = NUM_REQ'(1) << gnt_q;
                o_data  = data_q;
                o_err   = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sdio_cis_arbiter.sv
// Directed bench for sdio_cis_arbiter with a registered-read ROM model (ROM[i] = 0xA0 + i).
module tb_sdio_cis_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_req;
    logic [35:0] i_addr;
    logic [1:0]  o_ack;
    logic        o_err;
    logic [7:0]  o_data;
    logic        o_busy;
    logic        o_cis_activate;
    logic        o_cis_data_stb;
    logic [17:0] o_cis_address;
    logic [7:0]  rom_q;

    logic [7:0]  rom [256];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          stb_cnt = 0;

    sdio_cis_arbiter #(.NUM_REQ(2), .CIS_BASE(18'h01000), .CIS_SIZE(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .o_ack          (o_ack),
        .o_err          (o_err),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_cis_activate (o_cis_activate),
        .o_cis_data_stb (o_cis_data_stb),
        .o_cis_address  (o_cis_address),
        .i_cis_data     (rom_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_cis_data_stb) begin
            rom_q   <= rom[o_cis_address[7:0]];
            stb_cnt <= stb_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_ack(output int n, output logic [1:0] a, output logic [7:0] d, output logic e);
        n = -1; a = '0; d = '0; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (o_ack != 2'b00) begin
                n = c; a = o_ack; d = o_data; e = o_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = '0; i_addr = '0;
        #3;
        vec_cnt++;
        if ({o_ack, o_err, o_data, o_busy, o_cis_activate, o_cis_data_stb, o_cis_address} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: ack=%b err=%b data=%h busy=%b act=%b stb=%b addr=%h, want all 0",
                     o_ack, o_err, o_data, o_busy, o_cis_activate, o_cis_data_stb, o_cis_address);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_contention();
        int n; logic [1:0] a; logic [7:0] d; logic e;
        i_addr = {18'h01001, 18'h01000};
        i_req  = 2'b11;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e, o_busy} !== {32'sd3, 2'b01, 8'hA0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL contention_first: n=%0d ack=%b data=%h err=%b busy=%b, want 3/01/a0/0/1", n, a, d, e, o_busy);
        end
        i_req[0] = 1'b0;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e, o_busy} !== {32'sd4, 2'b10, 8'hA1, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL contention_second: n=%0d ack=%b data=%h err=%b busy=%b, want 4/10/a1/0/1", n, a, d, e, o_busy);
        end
        i_req = '0;
        step();
    endtask

    task automatic test_fairness();
        int n; logic [1:0] a; logic [7:0] d; logic e;
        int exp_n; logic [1:0] exp_a; logic [7:0] exp_d;
        i_addr = {18'h01020, 18'h01010};
        i_req  = 2'b11;
        for (int r = 0; r < 8; r++) begin
            run_until_ack(n, a, d, e);
            exp_n = (r == 0) ? 3 : 4;
            exp_a = (r % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (r % 2 == 0) ? 8'hB0 : 8'hC0;
            vec_cnt++;
            if ({n, a, d, e} !== {exp_n, exp_a, exp_d, 1'b0}) begin
                err_cnt++;
                $display("FAIL fairness_read%0d: n=%0d ack=%b data=%h err=%b, want %0d/%b/%h/0",
                         r, n, a, d, e, exp_n, exp_a, exp_d);
            end
        end
        i_req = '0;
        step();
    endtask

    task automatic test_single();
        int n; logic [1:0] a; logic [7:0] d; logic e; int s0;
        s0     = stb_cnt;
        i_addr = {18'h00000, 18'h01005};
        i_req  = 2'b01;
        step();
        vec_cnt++;
        if ({o_cis_data_stb, o_cis_activate, o_cis_address, o_busy} !== {1'b1, 1'b1, 18'h00005, 1'b1}) begin
            err_cnt++;
            $display("FAIL single_issue: stb=%b act=%b addr=%h busy=%b, want 1/1/00005/1",
                     o_cis_data_stb, o_cis_activate, o_cis_address, o_busy);
        end
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd2, 2'b01, 8'hA5, 1'b0}) begin
            err_cnt++;
            $display("FAIL single_ack: n=%0d (after issue) ack=%b data=%h err=%b, want 2/01/a5/0", n, a, d, e);
        end
        vec_cnt++;
        if (stb_cnt - s0 !== 1) begin
            err_cnt++;
            $display("FAIL single_strobes: got %0d strobes, want 1", stb_cnt - s0);
        end
        i_req = '0;
        step();
        vec_cnt++;
        if ({o_ack, o_data, o_err, o_busy} !== '0) begin
            err_cnt++;
            $display("FAIL single_idle: ack=%b data=%h err=%b busy=%b, want all 0", o_ack, o_data, o_err, o_busy);
        end
    endtask

    task automatic test_window();
        int n; logic [1:0] a; logic [7:0] d; logic e; int s0;
        i_addr = {18'h00000, 18'h010FF};
        i_req  = 2'b01;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd3, 2'b01, 8'h9F, 1'b0}) begin
            err_cnt++;
            $display("FAIL window_top: n=%0d ack=%b data=%h err=%b, want 3/01/9f/0", n, a, d, e);
        end
        i_req = '0;
        step();
        s0     = stb_cnt;
        i_addr = {18'h00000, 18'h01100};
        i_req  = 2'b01;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd1, 2'b01, 8'h00, 1'b1} || stb_cnt != s0) begin
            err_cnt++;
            $display("FAIL window_above: n=%0d ack=%b data=%h err=%b strobes=%0d, want 1/01/00/1/0",
                     n, a, d, e, stb_cnt - s0);
        end
        i_req = '0;
        step();
        s0     = stb_cnt;
        i_addr = {18'h00FFF, 18'h00000};
        i_req  = 2'b10;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd1, 2'b10, 8'h00, 1'b1} || stb_cnt != s0) begin
            err_cnt++;
            $display("FAIL window_below: n=%0d ack=%b data=%h err=%b strobes=%0d, want 1/10/00/1/0",
                     n, a, d, e, stb_cnt - s0);
        end
        i_req = '0;
        step();
    endtask

    task automatic test_addr_change();
        int n; logic [1:0] a; logic [7:0] d; logic e;
        i_addr = {18'h00000, 18'h01007};
        i_req  = 2'b01;
        step();
        step();
        i_addr[17:0] = 18'h01009;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd1, 2'b01, 8'hA7, 1'b0}) begin
            err_cnt++;
            $display("FAIL addr_change: n=%0d ack=%b data=%h err=%b, want 1/01/a7/0", n, a, d, e);
        end
        i_req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        int n; logic [1:0] a; logic [7:0] d; logic e;
        i_addr = {18'h01004, 18'h01003};
        i_req  = 2'b01;
        step();
        vec_cnt++;
        if (o_cis_data_stb !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_mid_issue: stb=%b, want 1", o_cis_data_stb);
        end
        i_req = 2'b11;
        #2 rst = 1'b0;
        #1;
        vec_cnt++;
        if ({o_cis_activate, o_cis_data_stb, o_cis_address, o_ack, o_busy, o_data, o_err} !== '0) begin
            err_cnt++;
            $display("FAIL reset_mid_async: act=%b stb=%b addr=%h ack=%b busy=%b data=%h err=%b, want all 0",
                     o_cis_activate, o_cis_data_stb, o_cis_address, o_ack, o_busy, o_data, o_err);
        end
        @(negedge clk);
        rst = 1'b1;
        run_until_ack(n, a, d, e);
        vec_cnt++;
        if ({n, a, d, e} !== {32'sd3, 2'b01, 8'hA3, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_mid_regrant: n=%0d ack=%b data=%h err=%b, want 3/01/a3/0", n, a, d, e);
        end
        i_req = '0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(8'hA0 + i);
        test_reset();
        test_contention();
        test_fairness();
        test_single();
        test_window();
        test_addr_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
